cic_interp_sdm: RTL and testbench

CIC_INTERP_SDM -- requirements
Module: cic_interp_sdm

---
 rtl/cic_pkg.sv | 16 +
 rtl/sdm1.sv | 38 +++
 rtl/cic_interp_sdm.sv | 127 ++++++++++++
 tb/tb_cic_interp_sdm.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared sizing helpers for CIC interpolators
package cic_pkg;

  // Register width that holds every comb/integrator value without loss:
  // input width plus log2(R) bits of growth per stage.
  function automatic int cic_acc_width(input int w, input int order, input int ratio);
    return w + order * $clog2(ratio);
  endfunction

  // Right shift that removes the R^(ORDER-1) passband gain of a
  // zero-stuffing interpolator, leaving a DC gain of exactly one.
  function automatic int cic_norm_shift(input int order, input int ratio);
    return (order - 1) * $clog2(ratio);
  endfunction

endpackage

// File: rtl/sdm1.sv
// rtl/sdm1.sv - first-order sigma-delta modulator, one output bit per clock
module sdm1 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x,
  output logic         dout
);

  // Feedback magnitude 2^(W-1): the analogue value of a +1 / -1 output bit.
  localparam logic signed [W+1:0] FB = {3'b001, {(W-1){1'b0}}};

  logic signed [W+1:0] r_err;
  logic                r_dout;
  logic signed [W+1:0] w_v;
  logic                w_bit;

  // Add the sign-extended input to the carried error and quantise on sign.
  always_comb begin
    w_v   = r_err + {{2{x[W-1]}}, x};
    w_bit = ~w_v[W+1];
  end

  // Carry the quantisation error forward and register the output bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err  <= '0;
      r_dout <= 1'b0;
    end else begin
      r_err  <= w_bit ? (w_v - FB) : (w_v + FB);
      r_dout <= w_bit;
    end
  end

  assign dout = r_dout;

endmodule

// File: rtl/cic_interp_sdm.sv
// rtl/cic_interp_sdm.sv - CIC interpolator feeding a first-order sigma-delta modulator
module cic_interp_sdm
  import cic_pkg::*;
#(
  parameter int ORDER        = 3,
  parameter int INTERP_RATIO = 64,
  parameter int INPUT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [INPUT_WIDTH-1:0] din,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          dout,
  output logic                          underrun
);

  localparam int W     = INPUT_WIDTH;
  localparam int ACC_W = cic_acc_width(W, ORDER, INTERP_RATIO);
  localparam int SHIFT = cic_norm_shift(ORDER, INTERP_RATIO);
  localparam int PH_W  = $clog2(INTERP_RATIO);

  localparam logic [PH_W-1:0]         PH_LAST = PH_W'(INTERP_RATIO - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI  = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO  = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  logic [PH_W-1:0]          r_phase;
  logic signed [W-1:0]      r_held;
  logic signed [ACC_W-1:0]  r_comb_dly [ORDER];
  logic signed [ACC_W-1:0]  r_comb_q;
  logic signed [ACC_W-1:0]  r_integ [ORDER];
  logic                     r_underrun;

  logic                     w_tick;
  logic signed [W-1:0]      w_sample;
  logic signed [ACC_W-1:0]  w_comb_in [ORDER];
  logic signed [ACC_W-1:0]  w_comb_out;
  logic signed [ACC_W-1:0]  w_stuffed;
  logic signed [ACC_W-1:0]  w_shifted;
  logic [W-1:0]             w_x;

  // The last phase of each period is the input slot.
  assign w_tick   = (r_phase == PH_LAST);
  assign in_ready = w_tick & ~rst;
  assign underrun = r_underrun;

  // Free-running phase counter, one full period per input sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= '0;
    end else begin
      r_phase <= w_tick ? '0 : r_phase + 1'b1;
    end
  end

  // Pick the new or held sample and run it through the comb cascade.
  always_comb begin : comb_chain
    logic signed [ACC_W-1:0] w_acc;
    w_sample = in_valid ? din : r_held;
    w_acc    = {{(ACC_W-W){w_sample[W-1]}}, w_sample};
    for (int k = 0; k < ORDER; k++) begin
      w_comb_in[k] = w_acc;
      w_acc        = w_acc - r_comb_dly[k];
    end
    w_comb_out = w_acc;
  end

  // Low-rate state: held sample, comb delays and comb result, updated on ticks only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_held     <= '0;
      r_comb_q   <= '0;
      r_underrun <= 1'b0;
      for (int k = 0; k < ORDER; k++) begin
        r_comb_dly[k] <= '0;
      end
    end else begin
      r_underrun <= w_tick & ~in_valid;
      if (w_tick) begin
        r_held   <= w_sample;
        r_comb_q <= w_comb_out;
        for (int k = 0; k < ORDER; k++) begin
          r_comb_dly[k] <= w_comb_in[k];
        end
      end
    end
  end

  // Zero-stuffing: the comb result enters the integrators once per period.
  assign w_stuffed = (r_phase == '0) ? r_comb_q : '0;

  // Pipelined integrator cascade at the full clock rate; wraps modulo 2^ACC_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ORDER; i++) begin
        r_integ[i] <= '0;
      end
    end else begin
      r_integ[0] <= r_integ[0] + w_stuffed;
      for (int i = 1; i < ORDER; i++) begin
        r_integ[i] <= r_integ[i] + r_integ[i-1];
      end
    end
  end

  // Remove the interpolation gain, then clamp to the W-bit modulator input range.
  always_comb begin
    w_shifted = r_integ[ORDER-1] >>> SHIFT;
    if (w_shifted > SAT_HI) begin
      w_x = SAT_HI[W-1:0];
    end else if (w_shifted < SAT_LO) begin
      w_x = SAT_LO[W-1:0];
    end else begin
      w_x = w_shifted[W-1:0];
    end
  end

  sdm1 #(
    .W(W)
  ) u_sdm (
    .clk  (clk),
    .rst  (rst),
    .x    (w_x),
    .dout (dout)
  );

endmodule

// File: tb/tb_cic_interp_sdm.sv
// tb/tb_cic_interp_sdm.sv - randomized self-checking bench for cic_interp_sdm
module tb_cic_interp_sdm;

  localparam int     R     = 64;
  localparam int     N     = 3;
  localparam int     W     = 16;
  localparam int     SHIFT = (N - 1) * 6;
  localparam int     HLEN  = N * (R - 1) + 1;
  localparam longint HALF  = 32768;

  logic               clk;
  logic               rst;
  logic signed [15:0] din;
  logic               in_valid;
  logic               in_ready;
  logic               dout;
  logic               underrun;

  cic_interp_sdm #(
    .ORDER        (N),
    .INTERP_RATIO (R),
    .INPUT_WIDTH  (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dout     (dout),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int     n_checks;
  int     n_errors;
  int     ready_cnt;
  int     m_e;
  longint m_err;
  longint m_held;
  int     tk_e [$];
  longint tk_s [$];
  longint h [HLEN];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Impulse response of the whole interpolator: R-point boxcar convolved N times.
  task automatic build_h();
    longint a [HLEN];
    longint b [HLEN];
    int     len;
    for (int i = 0; i < HLEN; i++) a[i] = (i < R) ? 1 : 0;
    len = R;
    for (int n = 1; n < N; n++) begin
      for (int i = 0; i < HLEN; i++) b[i] = 0;
      for (int i = 0; i < len + R - 1; i++)
        for (int j = 0; j < R; j++)
          if (i - j >= 0 && i - j < len) b[i] += a[i - j];
      len += R - 1;
      a = b;
    end
    h = a;
  endtask

  // Filter output after edge t: every accepted sample weighted by h, N edges of pipeline.
  function automatic longint model_y(input int t);
    longint acc;
    acc = 0;
    for (int i = 0; i < tk_e.size(); i++) begin
      int d;
      d = t - tk_e[i] - N;
      if (d >= 0 && d < HLEN) acc += tk_s[i] * h[d];
    end
    return acc;
  endfunction

  task automatic step();
    bit     tv;
    bit     tick;
    bit     b;
    bit     exp_under;
    longint td;
    longint y;
    longint x;
    longint v;
    longint s;
    tv = in_valid;
    td = longint'(din);
    @(posedge clk);
    m_e++;
    y = model_y(m_e - 1);
    x = y >>> SHIFT;
    if (x > 32767) x = 32767;
    if (x < -32768) x = -32768;
    v = m_err + x;
    b = (v >= 0);
    m_err = v - (b ? HALF : -HALF);
    tick = (m_e % R == 0);
    exp_under = tick && !tv;
    if (tick) begin
      s = tv ? td : m_held;
      m_held = s;
      tk_e.push_back(m_e);
      tk_s.push_back(s);
    end
    while (tk_e.size() > 0 && m_e - tk_e[0] - N >= HLEN) begin
      void'(tk_e.pop_front());
      void'(tk_s.pop_front());
    end
    #1;
    check_eq("dout", dout, b);
    check_eq("in_ready", in_ready, (m_e % R == R - 1));
    check_eq("underrun", underrun, exp_under);
    if (in_ready) ready_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_dout", dout, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_underrun", underrun, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_e = 0;
    m_err = 0;
    m_held = 0;
    tk_e.delete();
    tk_s.delete();
  endtask

  task automatic idle_check(input int n);
    int uc;
    uc = 0;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      check_eq("idle_pattern", dout, m_e % 2);
      if (underrun) uc++;
    end
    check_eq("idle_underrun_count", uc, n / R);
  endtask

  task automatic align_after_tick();
    while (m_e % R != 0) step();
  endtask

  task automatic align_before_tick();
    while (m_e % R != R - 1) step();
  endtask

  task automatic density_windows(input string tag, input int lo, input int hi);
    int ones;
    for (int w = 0; w < 3; w++) begin
      ones = 0;
      repeat (1024) begin
        step();
        if (dout) ones++;
      end
      check_eq(tag, (ones >= lo && ones <= hi), 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int first_dev;
    int ones;
    n_checks  = 0;
    n_errors  = 0;
    ready_cnt = 0;
    clk       = 1'b0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    din       = '0;
    m_e       = 0;
    m_err     = 0;
    m_held    = 0;
    build_h();
    #2;

    do_reset();
    idle_check(3 * R);

    do_reset();
    in_valid = 1'b1;
    repeat (R - 1) begin
      din = 16'($urandom);
      step();
    end
    check_eq("hs_first_ready", in_ready, 1);
    ready_cnt = 0;
    repeat (10 * R) begin
      din = 16'($urandom);
      step();
    end
    check_eq("hs_ready_count", ready_cnt, 10);

    repeat (40 * R) begin
      in_valid = ($urandom % 4) != 0;
      din = 16'($urandom);
      step();
    end

    do_reset();
    in_valid = 1'b1;
    din = 16'sd16384;
    repeat (16 * R) step();
    density_windows("dc_pos_density", 764, 772);
    din = -16'sd16384;
    repeat (16 * R) step();
    density_windows("dc_neg_density", 252, 260);

    align_after_tick();
    for (int blk = 0; blk < 4; blk++) begin
      din = (blk % 2 == 0) ? 16'sh7FFF : 16'sh8000;
      ones = 0;
      for (int c = 0; c < 8 * R; c++) begin
        step();
        if (c >= 320 && dout) ones++;
      end
      if (blk % 2 == 0) check_eq("fs_high_density", ones >= 186, 1);
      else              check_eq("fs_low_density", ones <= 6, 1);
    end

    do_reset();
    in_valid = 1'b1;
    din = '0;
    repeat (2 * R) step();
    align_before_tick();
    din = 16'sd16384;
    step();
    k = m_e;
    din = '0;
    first_dev = -1;
    for (int i = 0; i < 2000 && first_dev < 0; i++) begin
      step();
      if (dout !== 1'(m_e % 2)) first_dev = m_e;
    end
    check_eq("lat_deviation_found", first_dev > 0, 1);
    check_eq("lat_not_before_k_order_1", first_dev >= k + N + 1, 1);

    in_valid = 1'b1;
    align_after_tick();
    repeat (3) begin
      din = 16'($urandom);
      step();
    end
    do_reset();
    idle_check(3 * R);
    align_before_tick();
    do_reset();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
